// File: rtl/spi_slave.sv
// SPI mode-0 slave with a one-byte TX holding register, synchronized SPI inputs and
// single-cycle status pulses for completion, overrun, underrun and aborted frames.
module spi_slave #(
    parameter logic [7:0]  DEFAULT_TX  = 8'h00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       busy,
    output logic       done,
    output logic       rx_overrun,
    output logic       tx_underrun,
    output logic       abort
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_meta, cs_meta, mosi_meta;
    logic                   sclk_d, cs_d;
    logic                   sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    // cs chain resets low so a frame already in progress at reset release is not seen as a start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_meta <= '0;
            cs_meta   <= '0;
            mosi_meta <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_meta <= {sclk_meta[SYNC_STAGES-2:0], sclk};
            cs_meta   <= {cs_meta[SYNC_STAGES-2:0], cs};
            mosi_meta <= {mosi_meta[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_sync;
            cs_d      <= cs_sync;
        end
    end

    assign sclk_sync = sclk_meta[SYNC_STAGES-1];
    assign cs_sync   = cs_meta[SYNC_STAGES-1];
    assign mosi_sync = mosi_meta[SYNC_STAGES-1];
    assign sclk_rise = sclk_sync & ~sclk_d;
    assign sclk_fall = ~sclk_sync & sclk_d;
    assign cs_rise   = cs_sync & ~cs_d;
    assign cs_fall   = ~cs_sync & cs_d;

    logic [0:0] state_q, state_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       reload_q, reload_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       done_q, done_d;
    logic       overrun_q, overrun_d;
    logic       underrun_q, underrun_d;
    logic       abort_q, abort_d;
    logic       load;

    always_comb begin
        state_d     = state_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        reload_d    = reload_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        done_d      = 1'b0;
        overrun_d   = 1'b0;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;
        load        = 1'b0;

        if (rx_ack) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = SHIFT;
                    load       = 1'b1;
                    bit_cnt_d  = 3'd0;
                    reload_d   = 1'b0;
                    rx_shift_d = 7'd0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    reload_d  = 1'b0;
                    bit_cnt_d = 3'd0;
                    abort_d   = (bit_cnt_q != 3'd0);
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[5:0], mosi_sync};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        // Completion wins over a coincident ack, so rx_valid stays set
                        rx_data_d  = {rx_shift_q, mosi_sync};
                        rx_valid_d = 1'b1;
                        done_d     = 1'b1;
                        reload_d   = 1'b1;
                        overrun_d  = rx_valid_q & ~rx_ack;
                    end
                end else if (sclk_fall) begin
                    if (reload_q) begin
                        load     = 1'b1;
                        reload_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            hold_full_d = 1'b0;
            if (hold_full_q) begin
                tx_shift_d = hold_data_q;
            end else begin
                tx_shift_d = DEFAULT_TX;
                underrun_d = 1'b1;
            end
        end

        // A write accepted in the same cycle as a load refills the just-emptied register
        if (tx_valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_data_d = tx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tx_shift_q  <= 8'd0;
            rx_shift_q  <= 7'd0;
            bit_cnt_q   <= 3'd0;
            reload_q    <= 1'b0;
            hold_data_q <= 8'd0;
            hold_full_q <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            reload_q    <= reload_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
        end
    end

    assign busy        = (state_q == SHIFT);
    assign miso_oe     = busy;
    assign miso        = busy & tx_shift_q[7];
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign done        = done_q;
    assign rx_overrun  = overrun_q;
    assign tx_underrun = underrun_q;
    assign abort       = abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// Randomized bench for spi_slave: a bit-banged SPI master plus a byte-level model of
// what each frame should deliver in both directions and which status pulses it raises.
module tb_spi_slave;

    localparam logic [7:0] DEF = 8'h00;

    logic       clk = 1'b0, reset = 1'b0, sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
    logic       tx_valid = 1'b0, rx_ack = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso, miso_oe, tx_ready, rx_valid, busy, done;
    logic       rx_overrun, tx_underrun, abort;
    logic [7:0] rx_data;

    spi_slave #(.DEFAULT_TX(DEF), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack), .busy(busy), .done(done),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .abort(abort)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int n_done = 0, n_under = 0, n_over = 0, n_abort = 0;
    int hp = 4;

    logic [7:0] tx_q[4], mosi_b[4], got[4];
    bit         have_tx[4];
    bit         model_valid = 1'b0;
    logic [7:0] model_data = 8'h00;

    always @(negedge clk) begin
        n_done  <= n_done + int'(done);
        n_under <= n_under + int'(tx_underrun);
        n_over  <= n_over + int'(rx_overrun);
        n_abort <= n_abort + int'(abort);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tx_write(input logic [7:0] d);
        @(negedge clk);
        check("tx_ready_before_write", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_ready_after_write", tx_ready, 0);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        model_valid = 1'b0;
        check("rx_valid_after_ack", rx_valid, 0);
    endtask

    // Last sclk fall coincides with cs rise, as a master returning sclk low at deselect
    task automatic run_frame(input int nbits, input bit ack_last);
        logic [7:0] sh;
        sh = 8'h00;
        @(negedge clk);
        cs = 1'b0;
        repeat (hp + 4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = mosi_b[i/8][7-(i%8)];
            repeat (hp) @(negedge clk);
            sh   = {sh[6:0], miso};
            sclk = 1'b1;
            if (i % 8 == 7) got[i/8] = sh;
            if (ack_last && i == nbits - 1) begin
                repeat (2) @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
                repeat (hp - 3) @(negedge clk);
            end else if (i % 8 == 1 && (i / 8 + 1) * 8 < nbits && have_tx[i/8+1]) begin
                tx_write(tx_q[i/8+1]);
                repeat (hp - 2) @(negedge clk);
            end else begin
                repeat (hp) @(negedge clk);
            end
            sclk = 1'b0;
            if (i == nbits - 1) cs = 1'b1;
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic do_frame(input string name, input int nbits, input bit ack_last);
        int d0, u0, o0, a0, nfull, exp_u, exp_o;
        bit pend;
        logic [7:0] exp_b;
        d0 = n_done; u0 = n_under; o0 = n_over; a0 = n_abort;
        if (have_tx[0]) tx_write(tx_q[0]);
        run_frame(nbits, ack_last);
        nfull = nbits / 8;
        exp_u = have_tx[0] ? 0 : 1;
        exp_o = 0;
        pend  = model_valid;
        for (int i = 0; i < nfull; i++) begin
            exp_b = have_tx[i] ? tx_q[i] : DEF;
            check($sformatf("%s_miso_byte%0d", name, i), got[i], exp_b);
            if (i > 0 && !have_tx[i]) exp_u++;
            if (pend && !(ack_last && i == nfull - 1)) exp_o++;
            pend = 1'b1;
        end
        if (nfull > 0) begin
            model_valid = 1'b1;
            model_data  = mosi_b[nfull-1];
        end
        check({name, "_rx_data"}, rx_data, model_data);
        check({name, "_rx_valid"}, rx_valid, model_valid);
        check({name, "_done_cnt"}, n_done - d0, nfull);
        check({name, "_underrun_cnt"}, n_under - u0, exp_u);
        check({name, "_overrun_cnt"}, n_over - o0, exp_o);
        check({name, "_abort_cnt"}, n_abort - a0, (nbits % 8 != 0) ? 1 : 0);
        check({name, "_tx_ready"}, tx_ready, 1);
        check({name, "_idle"}, {busy, miso_oe, miso}, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_miso"}, miso, 0);
        check({name, "_miso_oe"}, miso_oe, 0);
        check({name, "_tx_ready"}, tx_ready, 1);
        check({name, "_rx_data"}, rx_data, 0);
        check({name, "_rx_valid"}, rx_valid, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_pulses"}, {done, rx_overrun, tx_underrun, abort}, 0);
    endtask

    initial begin
        int d0, a0, nb;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte, TX preloaded
        hp = 4;
        have_tx[0] = 1'b1; tx_q[0] = 8'hA5; mosi_b[0] = 8'h3C;
        do_frame("single", 8, 1'b0);
        ack_pulse();

        // No TX byte: default byte and one underrun
        have_tx[0] = 1'b0; mosi_b[0] = 8'hFF;
        do_frame("underrun", 8, 1'b0);
        ack_pulse();

        // Two back-to-back bytes, never acknowledged
        have_tx[0] = 1'b1; tx_q[0] = 8'h11; have_tx[1] = 1'b1; tx_q[1] = 8'h22;
        mosi_b[0] = 8'h96; mosi_b[1] = 8'h4B;
        do_frame("two_byte", 16, 1'b0);
        ack_pulse();

        // Abort after 5 rises, then a good frame
        have_tx[0] = 1'b1; tx_q[0] = 8'hC3; mosi_b[0] = 8'hE7;
        do_frame("abort", 5, 1'b0);
        have_tx[0] = 1'b1; tx_q[0] = 8'h3E; mosi_b[0] = 8'h81;
        do_frame("after_abort", 8, 1'b0);

        // Ack coincides with completion while the previous byte is still unread
        have_tx[0] = 1'b0; mosi_b[0] = 8'h5D;
        do_frame("ack_coincide", 8, 1'b1);

        // sclk activity with cs high is ignored
        d0 = n_done; a0 = n_abort;
        for (int i = 0; i < 16; i++) begin
            sclk = ~sclk;
            repeat (hp) @(negedge clk);
        end
        check("cs_high_done_cnt", n_done - d0, 0);
        check("cs_high_abort_cnt", n_abort - a0, 0);
        check("cs_high_rx_data", rx_data, model_data);

        // Reset mid-frame after 3 bits
        have_tx[0] = 1'b1; tx_q[0] = 8'h77;
        tx_write(8'h77);
        @(negedge clk);
        cs = 1'b0;
        repeat (hp + 4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            mosi = i[0];
            repeat (hp) @(negedge clk);
            sclk = 1'b1;
            repeat (hp) @(negedge clk);
            sclk = 1'b0;
        end
        a0 = n_abort;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("mid_reset");
        cs = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_reset_no_abort", n_abort - a0, 0);
        model_valid = 1'b0;
        model_data  = 8'h00;
        have_tx[0] = 1'b1; tx_q[0] = 8'h5A; mosi_b[0] = 8'hA6;
        do_frame("after_reset", 8, 1'b0);

        // Randomized frames
        for (int it = 0; it < 12; it++) begin
            hp = 4 + int'($urandom_range(0, 2));
            nb = 1 + int'($urandom_range(0, 2));
            for (int j = 0; j < 4; j++) begin
                have_tx[j] = 1'($urandom_range(0, 1));
                tx_q[j]    = 8'($urandom);
                mosi_b[j]  = 8'($urandom);
            end
            if ($urandom_range(0, 1) == 1 && rx_valid) ack_pulse();
            do_frame($sformatf("rand%0d", it), 8 * nb, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
